// File: rtl/core_pkg.sv
// Shared types for the RV32I fetch path: next-PC selects, fetch FSM states and the reset vector.
package core_pkg;

    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        PC_SEQ    = 3'd0,
        PC_JALR   = 3'd1,
        PC_BRANCH = 3'd2,
        PC_JAL    = 3'd3,
        PC_MTVEC  = 3'd4,
        PC_MEPC   = 3'd5
    } pc_src_t;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC mux: picks the target, clears the jalr LSB and diverts misaligned targets to mtvec.
module pc_next_sel
    import core_pkg::*;
#(
    parameter int PC_STEP = 4
) (
    input  logic [31:0] i_pc,
    input  logic [2:0]  i_pc_source,
    input  logic [31:0] i_jalr,
    input  logic [31:0] i_branch,
    input  logic [31:0] i_jal,
    input  logic [31:0] i_mtvec,
    input  logic [31:0] i_mepc,
    output logic [31:0] o_target,
    output logic [31:0] o_next_pc,
    output logic        o_misalign
);

    always_comb begin
        o_target = i_pc + 32'(PC_STEP);
        case (pc_src_t'(i_pc_source))
            PC_JALR:   o_target = {i_jalr[31:1], 1'b0};
            PC_BRANCH: o_target = i_branch;
            PC_JAL:    o_target = i_jal;
            PC_MTVEC:  o_target = i_mtvec;
            PC_MEPC:   o_target = i_mepc;
            default:   o_target = i_pc + 32'(PC_STEP);
        endcase
    end

    // The trap vector is trusted, so only non-mtvec targets can fault.
    assign o_misalign = (i_pc_source != PC_MTVEC) && (o_target[1:0] != 2'b00);
    assign o_next_pc  = o_misalign ? i_mtvec : o_target;

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC plus a single-outstanding instruction fetch (req/gnt/rvalid) feeding decode.
module pc_fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
    parameter int          PC_STEP   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pc_write,
    input  logic [2:0]  i_pc_source,
    input  logic [31:0] i_jalr,
    input  logic [31:0] i_branch,
    input  logic [31:0] i_jal,
    input  logic [31:0] i_mtvec,
    input  logic [31:0] i_mepc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_valid,
    output logic [31:0] o_pc,
    output logic        o_misalign,
    output logic [31:0] o_fault_addr
);

    fetch_state_t r_state;
    logic         r_kill;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic [31:0]  r_instr_pc;
    logic         r_instr_valid;
    logic         r_misalign;
    logic [31:0]  r_fault_addr;

    logic [31:0]  w_target;
    logic [31:0]  w_next_pc;
    logic         w_misalign;

    pc_next_sel #(.PC_STEP(PC_STEP)) u_next_sel (
        .i_pc        (r_pc),
        .i_pc_source (i_pc_source),
        .i_jalr      (i_jalr),
        .i_branch    (i_branch),
        .i_jal       (i_jal),
        .i_mtvec     (i_mtvec),
        .i_mepc      (i_mepc),
        .o_target    (w_target),
        .o_next_pc   (w_next_pc),
        .o_misalign  (w_misalign)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ISSUE;
            r_kill        <= 1'b0;
            r_pc          <= RESET_VEC;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_misalign    <= 1'b0;
            r_fault_addr  <= '0;
        end else begin
            r_misalign <= 1'b0;
            if (i_pc_write) begin
                r_pc <= w_next_pc;
                if (w_misalign) begin
                    r_misalign   <= 1'b1;
                    r_fault_addr <= w_target;
                end
            end
            case (r_state)
                // A grant in the same cycle as a redirect fetched the stale PC.
                ISSUE: if (i_imem_gnt) begin
                    r_state <= WAIT;
                    r_kill  <= i_pc_write;
                end
                WAIT: begin
                    if (i_imem_rvalid) begin
                        if (r_kill || i_pc_write) begin
                            r_kill  <= 1'b0;
                            r_state <= ISSUE;
                        end else begin
                            r_instr       <= i_imem_rdata;
                            r_instr_pc    <= r_pc;
                            r_instr_valid <= 1'b1;
                            r_state       <= HOLD;
                        end
                    end else if (i_pc_write) begin
                        r_kill <= 1'b1;
                    end
                end
                HOLD: if (i_pc_write) begin
                    r_instr_valid <= 1'b0;
                    r_state       <= ISSUE;
                end
                default: r_state <= ISSUE;
            endcase
        end
    end

    assign o_imem_req    = (r_state == ISSUE) && !i_rst;
    assign o_imem_addr   = r_pc;
    assign o_pc          = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_instr_valid = r_instr_valid;
    assign o_misalign    = r_misalign;
    assign o_fault_addr  = r_fault_addr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: delay-programmable memory model plus an instruction scoreboard.
module tb_pc_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, pc_write;
    logic [2:0]  pc_source;
    logic [31:0] jalr, branch, jal, mtvec, mepc;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        o_imem_req, o_instr_valid, o_misalign;
    logic [31:0] o_imem_addr, o_instr, o_instr_pc, o_pc, o_fault_addr;

    int   n_chk = 0;
    int   n_err = 0;
    int   rv_delay = 1;
    exp_t sb_q[$];

    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] maddr = '0;
    logic        inflight = 1'b0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pc_write    (pc_write),
        .i_pc_source   (pc_source),
        .i_jalr        (jalr),
        .i_branch      (branch),
        .i_jal         (jal),
        .i_mtvec       (mtvec),
        .i_mepc        (mepc),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (gnt),
        .i_imem_rvalid (rvalid),
        .i_imem_rdata  (rdata),
        .o_instr       (o_instr),
        .o_instr_pc    (o_instr_pc),
        .o_instr_valid (o_instr_valid),
        .o_pc          (o_pc),
        .o_misalign    (o_misalign),
        .o_fault_addr  (o_fault_addr)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Memory: one outstanding read, data returned rv_delay cycles after the grant.
    initial begin
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        forever begin
            @(negedge clk);
            rvalid = 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    rvalid = 1'b1;
                    rdata  = mem_word(maddr);
                    pend   = 1'b0;
                end else begin
                    cnt--;
                end
            end
            gnt = o_imem_req && !pend && !rvalid;
            if (gnt) begin
                pend  = 1'b1;
                cnt   = rv_delay;
                maddr = o_imem_addr;
            end
        end
    end

    // Scoreboard producer: a granted fetch is expected unless a redirect or reset kills it first.
    initial begin
        forever begin
            @(posedge clk);
            if (gnt) begin
                sb_q.push_back('{maddr, mem_word(maddr)});
                inflight = 1'b1;
            end
            if ((pc_write || rst) && inflight) begin
                sb_q.delete(sb_q.size() - 1);
                inflight = 1'b0;
            end else if (rvalid && inflight) begin
                inflight = 1'b0;
            end
        end
    end

    // Scoreboard consumer: every new INSTR_VALID must match the oldest expected fetch.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (o_instr_valid && !prev) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_instr", o_instr, e.instr);
                    chk("sb_instr_pc", o_instr_pc, e.pc);
                end
            end
            prev = o_instr_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_write(input logic [2:0] src);
        @(posedge clk); #2;
        pc_source = src;
        pc_write  = 1'b1;
        @(posedge clk); #2;
        pc_write  = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic wait_valid(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk); #2;
            seen = o_instr_valid;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        logic saw;
        rst = 1'b1; pc_write = 1'b0; pc_source = 3'd0;
        jalr = '0; branch = '0; jal = '0; mtvec = 32'h80; mepc = '0;

        @(posedge clk); @(negedge clk); #1;
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_req", 32'(o_imem_req), 32'd0);
        chk("rst_valid", 32'(o_instr_valid), 32'd0);
        chk("rst_instr", o_instr, 32'h0);
        chk("rst_misalign", 32'(o_misalign), 32'd0);
        chk("rst_fault", o_fault_addr, 32'h0);
        @(posedge clk); #2 rst = 1'b0;

        @(negedge clk); #1;
        chk("first_req", 32'(o_imem_req), 32'd1);
        chk("first_addr", o_imem_addr, 32'h0);
        wait_valid("first_valid");
        chk("first_instr", o_instr, 32'h13);
        chk("first_instr_pc", o_instr_pc, 32'h0);

        do_write(3'd0);
        chk("seq_pc", o_pc, 32'h4);
        chk("seq_addr", o_imem_addr, 32'h4);
        chk("seq_req", 32'(o_imem_req), 32'd1);
        chk("seq_valid_drop", 32'(o_instr_valid), 32'd0);
        wait_valid("seq_valid");

        branch = 32'h100;
        do_write(3'd2);
        chk("br_pc", o_pc, 32'h100);
        chk("br_mis", 32'(o_misalign), 32'd0);
        wait_valid("br_valid");
        jal = 32'h40;
        do_write(3'd3);
        chk("jal_pc", o_pc, 32'h40);
        chk("jal_mis", 32'(o_misalign), 32'd0);
        wait_valid("jal_valid");

        jalr = 32'h201;
        do_write(3'd1);
        chk("jalr_pc", o_pc, 32'h200);
        chk("jalr_mis", 32'(o_misalign), 32'd0);
        wait_valid("jalr_valid");
        jalr = 32'h202;
        do_write(3'd1);
        chk("mis_pc", o_pc, 32'h80);
        chk("mis_pulse", 32'(o_misalign), 32'd1);
        chk("mis_fault", o_fault_addr, 32'h202);
        @(negedge clk); #1;
        chk("mis_pulse_end", 32'(o_misalign), 32'd0);
        chk("mis_fault_hold", o_fault_addr, 32'h202);
        wait_valid("mis_valid");

        // Trap redirect while a slow fetch is outstanding.
        rv_delay = 5;
        do_write(3'd0);
        chk("slow_pc", o_pc, 32'h84);
        do_write(3'd4);
        rv_delay = 1;
        chk("trap_pc", o_pc, 32'h80);
        saw = 1'b0;
        for (int i = 0; i < 20 && !o_imem_req; i++) begin
            @(negedge clk); #1;
            saw = saw | o_instr_valid;
        end
        chk("trap_drop_valid", 32'(saw), 32'd0);
        chk("trap_req", 32'(o_imem_req), 32'd1);
        chk("trap_addr", o_imem_addr, 32'h80);
        wait_valid("trap_valid");

        // Redirect in the same cycle the data returns.
        rv_delay = 3;
        do_write(3'd0);
        rv_delay = 1;
        for (int i = 0; i < 20 && !rvalid; i++) begin
            @(negedge clk); #1;
        end
        chk("coinc_rvalid_seen", 32'(rvalid), 32'd1);
        mepc = 32'h300; pc_source = 3'd5; pc_write = 1'b1;
        @(posedge clk); #2 pc_write = 1'b0;
        @(negedge clk); #1;
        chk("coinc_valid", 32'(o_instr_valid), 32'd0);
        chk("coinc_req", 32'(o_imem_req), 32'd1);
        chk("coinc_addr", o_imem_addr, 32'h300);
        wait_valid("coinc_valid_after");

        jal = 32'hFFFF_FFFC;
        do_write(3'd3);
        chk("top_pc", o_pc, 32'hFFFF_FFFC);
        wait_valid("top_valid");
        do_write(3'd0);
        chk("wrap_pc", o_pc, 32'h0);
        chk("wrap_mis", 32'(o_misalign), 32'd0);
        wait_valid("wrap_valid");
        do_write(3'd6);
        chk("rsvd_pc", o_pc, 32'h4);
        wait_valid("rsvd_valid");

        // Reset while waiting for data; the PC_WRITE during reset must be ignored.
        rv_delay = 4;
        do_write(3'd0);
        chk("rstw_pc", o_pc, 32'h8);
        @(posedge clk); #2;
        rst = 1'b1; pc_write = 1'b1; pc_source = 3'd3; jal = 32'h500;
        @(negedge clk); #1;
        chk("rstw_req_low", 32'(o_imem_req), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0; pc_write = 1'b0;
        rv_delay = 1;
        @(negedge clk); #1;
        chk("rstw_pc_vec", o_pc, 32'h0);
        chk("rstw_valid", 32'(o_instr_valid), 32'd0);
        chk("rstw_req", 32'(o_imem_req), 32'd1);
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            saw = saw | o_instr_valid;
        end
        chk("rstw_late_ignored", 32'(saw), 32'd0);
        chk("rstw_pc_still", o_pc, 32'h0);
        wait_valid("rstw_valid_after");

        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
